// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline memory arbiter.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2,
    ERR   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline request/hit signals plus the single-port RAM handshake.
// The arbiter is the slave; the pipeline/RAM environment is the master.
interface mem_arbiter_if #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32
);

  logic              iREN;
  logic [AWIDTH-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [AWIDTH-1:0] daddr;
  logic [DWIDTH-1:0] dstore;
  logic              ihit;
  logic [DWIDTH-1:0] iload;
  logic              dhit;
  logic [DWIDTH-1:0] dload;
  logic              busy;
  logic              err;
  logic              ram_req;
  logic              ram_wen;
  logic [AWIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0] ram_wdata;
  logic [DWIDTH-1:0] ram_rdata;
  logic              ram_ack;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_rdata, ram_ack,
    output ihit, iload, dhit, dload, busy, err, ram_req, ram_wen, ram_addr, ram_wdata
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_rdata, ram_ack,
    input  ihit, iload, dhit, dload, busy, err, ram_req, ram_wen, ram_addr, ram_wdata
  );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Watchdog for an outstanding RAM access: counts unacknowledged cycles,
// saturating, and flags the last allowed cycle. TIMEOUT = 0 never expires.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic CLK,
  input  logic sRST,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT != 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT != 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt;

  // Clear on access entry, count waiting cycles, hold at all-ones.
  always_ff @(posedge CLK) begin
    if (sRST || clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetches and data loads/stores onto one single-port
// RAM. Data wins ties, accesses are never preempted, and an access the RAM
// never acknowledges parks the arbiter in a sticky error state.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned AWIDTH  = 32,
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input logic           CLK,
  input logic           sRST,
  mem_arbiter_if.slave  bus
);

  arb_state_t        state, state_nxt;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic              op_q;
  logic              in_acc;
  logic              expired;

  assign in_acc = (state == D_ACC) || (state == I_ACC);

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .CLK     (CLK),
    .sRST    (sRST),
    .clr     (state == IDLE),
    .en      (in_acc && !bus.ram_ack),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (sRST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the winning request's address/data/op while accepting it in IDLE.
  always_ff @(posedge CLK) begin
    if (sRST) begin
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.dREN || bus.dWEN) begin
        addr_q  <= bus.daddr;
        wdata_q <= bus.dstore;
        op_q    <= bus.dWEN;
      end else if (bus.iREN) begin
        addr_q  <= bus.iaddr;
      end
    end
  end

  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.busy      = (state != IDLE);

  // Next-state selection and combinational decode of the RAM request and hits.
  always_comb begin
    state_nxt   = state;
    bus.ram_req = 1'b0;
    bus.ram_wen = 1'b0;
    bus.ihit    = 1'b0;
    bus.iload   = '0;
    bus.dhit    = 1'b0;
    bus.dload   = '0;
    bus.err     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.dREN || bus.dWEN) begin
          state_nxt = D_ACC;
        end else if (bus.iREN) begin
          state_nxt = I_ACC;
        end
      end
      D_ACC: begin
        bus.ram_req = 1'b1;
        bus.ram_wen = op_q;
        if (bus.ram_ack) begin
          bus.dhit  = 1'b1;
          bus.dload = op_q ? '0 : bus.ram_rdata;
          state_nxt = IDLE;
        end else if (expired) begin
          state_nxt = ERR;
        end
      end
      I_ACC: begin
        bus.ram_req = 1'b1;
        if (bus.ram_ack) begin
          bus.ihit  = 1'b1;
          bus.iload = bus.ram_rdata;
          state_nxt = IDLE;
        end else if (expired) begin
          state_nxt = ERR;
        end
      end
      ERR: begin
        bus.err = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
